// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serialiser, LSB first, programmable baud divider.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH queue; otherwise one holding reg.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wdata,
  input  logic       wvalid,
  output logic       wready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2) begin : g_cfg_err
    $error("uart_tx: CLKS_PER_BIT and FIFO_DEPTH must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    sh, sh_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic          tx_d;
  logic          pop;
  logic          push;
  logic          empty;
  logic [7:0]    head;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr, rptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        full;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign wready = !full;
  assign push  = wvalid && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
`else
  logic       hold_v;
  logic [7:0] hold_q;

  assign empty  = !hold_v;
  assign head   = hold_q;
  assign wready = !hold_v;
  assign push   = wvalid && !hold_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else begin
      if (pop) hold_v <= 1'b0;
      if (push) begin
        hold_v <= 1'b1;
        hold_q <= wdata;
      end
    end
  end
`endif

  always_comb begin
    state_d = state;
    sh_d    = sh;
    cnt_d   = cnt;
    idx_d   = idx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          state_d = START;
        end
      end
      START: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          sh_d  = sh >> 1;
          idx_d = idx + 1'b1;
          if (idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // line level follows the state being entered so tx stays a plain flop
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      sh    <= sh_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      tx    <= tx_d;
    end
  end

  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed frames against a frame-timeline model.
// Builds with or without UART_TX_FIFO_EN.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FLEN = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
  localparam int EARLY = 5;
`else
  localparam int CAP = 1;
  localparam int EARLY = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = '0;
  logic       m_push = 1'b0;
  int         m_frames = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wdata(wdata),
    .wvalid(wvalid),
    .wready(wready),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  // advance the model by one edge using the inputs the DUT is about to see
  task automatic model_step();
    logic fend;
    logic can_pop;
    m_push  = wvalid && (m_q.size() < CAP);
    fend    = m_active && (m_pos == FLEN - 1);
    can_pop = (!m_active || fend) && (m_q.size() > 0);
    if (fend) m_frames++;
    if (can_pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else if (fend) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_pos++;
    end
    if (m_push) m_q.push_back(wdata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(m_active || m_q.size() > 0));
    check("wready", 32'(wready), 32'(m_q.size() < CAP));
  endtask

  task automatic send(logic [7:0] b);
    bit ok = 0;
    wvalid = 1'b1;
    wdata  = b;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (m_push) begin
        ok = 1;
        break;
      end
    end
    wvalid = 1'b0;
    check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_active && m_q.size() == 0) begin
        ok = 1;
        break;
      end
      cycle();
    end
    check("drain_timeout", 32'(ok), 32'd1);
  endtask

  // called just after a rising edge; asserts reset between edges
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    m_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    wvalid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    int busy_cnt;
    int acc;
    int early;
    int f0;
    bit ok;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_tx", 32'(tx), 32'd1);
    check("init_wready", 32'(wready), 32'd1);
    check("init_busy", 32'(busy), 32'd0);
    cycle();
    mid_reset();

    // single byte, busy window
    busy_cnt = 0;
    send(8'h55);
    if (busy) busy_cnt++;
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (busy) busy_cnt++;
    end
    check("busy_len", 32'(busy_cnt), 32'd41);
    check("frames_1", 32'(m_frames), 32'd1);

    // back-to-back
    f0 = m_frames;
    send(8'hA5);
    send(8'h3C);
    drain();
    check("frames_2", 32'(m_frames - f0), 32'd2);

    // fill with wvalid held
    acc   = 0;
    early = 0;
    wdata = 8'h00;
    wvalid = 1'b1;
    for (int i = 0; i < 400 && acc < 5; i++) begin
      cycle();
      if (m_push) begin
        acc++;
        if (i < 10) early++;
        wdata = wdata + 8'h01;
      end
    end
    wvalid = 1'b0;
    check("fill_early", 32'(early), 32'(EARLY));
    check("fill_total", 32'(acc), 32'd5);
    drain();

    // reset during data bit 3 with bytes queued
    send(8'hF0);
    wvalid = 1'b1;
    wdata  = 8'h11;
    cycle();
    wdata  = 8'h22;
    cycle();
    wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_active && m_byte == 8'hF0 && m_pos == 4 * CPB + 1) begin
        ok = 1;
        break;
      end
      cycle();
    end
    check("reach_bit3", 32'(ok), 32'd1);
    mid_reset();
    for (int i = 0; i < 50; i++) cycle();
    check("post_rst_busy", 32'(busy), 32'd0);

    // wrap-around with gaps
    f0 = m_frames;
    for (int n = 0; n < 9; n++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 30)) cycle();
    end
    drain();
    check("wrap_frames", 32'(m_frames - f0), 32'd9);

    // random valid pattern
    for (int i = 0; i < 1500; i++) begin
      wvalid = ($urandom_range(0, 3) == 0);
      wdata  = 8'($urandom);
      cycle();
    end
    wvalid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
